// File: rtl/mem_block_responder_if.sv
// Block-granular miss interface between a cache controller (master)
// and the memory responder (slave).
interface mem_block_responder_if #(
    parameter int c_line_size  = 32,
    parameter int c_block_size = 2
);
    localparam int BLK_W = c_line_size * (2 ** c_block_size);

    logic                   m_read_i;
    logic                   m_write_i;
    logic [c_line_size-1:0] m_address_i;
    logic [BLK_W-1:0]       m_writedata_i;
    logic [BLK_W-1:0]       m_readdata_o;
    logic                   m_busywait_o;
    logic                   m_ack_o;

    modport master (
        output m_read_i, m_write_i, m_address_i, m_writedata_i,
        input  m_readdata_o, m_busywait_o, m_ack_o
    );

    modport slave (
        input  m_read_i, m_write_i, m_address_i, m_writedata_i,
        output m_readdata_o, m_busywait_o, m_ack_o
    );
endinterface

// File: rtl/mem_block_responder.sv
// Main-memory responder: latches one block read/write request, holds busywait
// for m_latency cycles, then returns/commits the whole block and pulses ack.
//
//   state  | meaning
//   IDLE   | waiting for a read or write request
//   BUSY   | request latched, latency timer counting down to zero
//   DONE   | ack cycle; requests ignored, back to IDLE next edge
module mem_block_responder #(
    parameter int c_line_size  = 32,
    parameter int c_block_size = 2,
    parameter int m_addr_bits  = 10,
    parameter int m_latency    = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    mem_block_responder_if.slave  bus
);
    localparam int WORDS  = 2 ** c_block_size;
    localparam int BLK_W  = c_line_size * WORDS;
    localparam int IDX_LO = c_block_size + 2;
    localparam int IDX_HI = m_addr_bits + 1;
    localparam int IDX_W  = IDX_HI - IDX_LO + 1;
    localparam int DEPTH  = 2 ** IDX_W;
    localparam logic [7:0] LAT_M1 = 8'(m_latency - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BLK_W-1:0] wdata_q, wdata_d;
    logic [BLK_W-1:0] rdata_q, rdata_d;
    logic             is_wr_q, is_wr_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             mem_we;
    logic [IDX_W-1:0] req_idx;
    logic             unused_addr_bits;

    logic [BLK_W-1:0] mem_q [DEPTH];

    // Upper address bits alias onto the same storage; byte/word offset is ignored.
    assign req_idx          = bus.m_address_i[IDX_HI:IDX_LO];
    assign unused_addr_bits = ^{bus.m_address_i[c_line_size-1:IDX_HI+1],
                                bus.m_address_i[IDX_LO-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        is_wr_d = is_wr_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.m_write_i || bus.m_read_i) begin
                    idx_d   = req_idx;
                    wdata_d = bus.m_writedata_i;
                    is_wr_d = bus.m_write_i;
                    cnt_d   = LAT_M1;
                    busy_d  = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                    if (is_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            is_wr_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_wr_q <= is_wr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    // Storage is deliberately not reset; an aborted write never raises mem_we.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.m_readdata_o = rdata_q;
    assign bus.m_busywait_o = busy_q;
    assign bus.m_ack_o      = ack_q;
endmodule
